hms_clock_core: RTL and testbench
=================================

# hms_clock_core

Single-clock hour:minute:second timekeeping core with an integrated button front end and a setup state machine. It is the parametrised successor to the team's minute:second clock. All logic runs on `clk` with clock enables; there are no derived clocks or switch-driven clocks. It adds an hour field, a selectable 24 h or 12 h range, a three-field setup mode and a blink flag for the display. It sits between the raw board buttons and the existing digit-split, segment-decode and six-digit multiplex path.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: `clk` cycles per one-second tick; must be ≥ 4 and even.
- `DEB_CYC`, default 500_000: cycles a synchronised button level must stay stable before it is accepted.
- `H24`, default 1: 1 gives hours 0–23; 0 gives hours 1–12.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; asynchronous, active-high.
- `i_sw_mode`  in  1  raw mode button, active-low, asynchronous to `clk`.
- `i_sw_pos`  in  1  raw field-select button, active-low.
- `i_sw_inc`  in  1  raw increment button, active-low.
- `o_sec`  out  6  seconds, binary, 0–59.
- `o_min`  out  6  minutes, binary, 0–59.
- `o_hour`  out  5  hours, binary.
- `o_mode`  out  1  0 = CLOCK, 1 = SETUP.
- `o_pos`  out  2  selected field: 0 = SEC, 1 = MIN, 2 = HOUR. Value 3 never occurs.
- `o_sec_tick`  out  1  one-cycle pulse on the cycle the time advances by a tick.
- `o_blink`  out  1  display blink flag for the selected field.

## Operation
- **Button front end, per button:**
  - 2-FF synchroniser.
  - Stability counter: the accepted level updates only after `DEB_CYC` consecutive equal samples.
  - A press event is a one-cycle pulse on the accepted 1→0 transition. Release produces no event.
- **Prescaler:** counts 0..`TICK_DIV`-1 in CLOCK mode. At terminal count it wraps and issues a tick. In SETUP it is held at 0.
- **Tick carry chain, all fields updated on the same edge:**
  - `o_sec` 59→0 carries into the minute field.
  - `o_min` 59→0 carries into the hour field.
  - With `H24`=1: hour 23→0, so 23:59:59 → 00:00:00.
  - With `H24`=0: hour 12→1, so 12:59:59 → 01:00:00.
- **Mode FSM, states CLOCK and SETUP:**
  - A mode event toggles the state.
  - Entering SETUP does not change `o_pos`.
  - Leaving SETUP restarts the prescaler from 0.
- **In SETUP:**
  - A pos event advances SEC→MIN→HOUR→SEC.
  - An inc event increments only the selected field, wrapping within that field's range (seconds 59→0, minutes 59→0, hours per `H24`) with no carry into the next field.
- **Events in CLOCK:** pos and inc events are ignored.
- **Simultaneous events:**
  - Mode and inc in the same cycle: the mode toggle applies, inc is dropped.
  - pos and inc in the same cycle in SETUP: inc applies to the old field, then pos advances.
- **`o_blink`:**
  - Constant 1 in CLOCK.
  - In SETUP, toggles every `TICK_DIV`/2 cycles, counted from SETUP entry, starting from 1.

## Timing
- **Reset values, applied immediately on `rst` assertion:**
  - `o_sec`=0, `o_min`=0, `o_mode`=0, `o_pos`=0, `o_sec_tick`=0, `o_blink`=1.
  - `o_hour`=0 when `H24`=1, 12 when `H24`=0.
  - Prescaler, debounce counters, synchronisers and accepted levels (released = 1) are also reset.
- `rst` asserted mid-count or mid-setup abandons all state. The first tick after release comes `TICK_DIV` cycles after the first `clk` edge with `rst` low.
- Ticks occur every `TICK_DIV` cycles exactly. `o_sec_tick` is high in the same cycle the new time is visible on the outputs.
- Button latency: a clean press held from cycle 0 produces its event at cycle 2+`DEB_CYC`. Fields and mode update on the next edge.
- A press shorter than `DEB_CYC` stable samples produces no event.
- A held button produces exactly one event; there is no auto-repeat.
- All outputs are registered and glitch-free.

## Structure
- **Package `hms_pkg`:**
  - Mode encodings `MODE_CLOCK`, `MODE_SETUP`.
  - Position encodings `POS_SEC`, `POS_MIN`, `POS_HOUR`.
  - Constants `SEC_MAX`=59, `MIN_MAX`=59.
  - Hour min/max functions of `H24`.
- **Sub-module `sw_debounce`:** synchroniser, stability counter and falling-edge event. Parameter `DEB_CYC`; ports `clk`, `rst`, `i_sw`, `o_level`, `o_press`. Instantiated three times.
- The top level holds the prescaler, mode/position FSM, field counters and blink counter.

## Test plan
Bench parameters: `TICK_DIV`=10, `DEB_CYC`=4.
1. **Reset:** assert `rst` mid-run → all outputs take reset values without waiting for a clock edge; first `o_sec_tick` occurs 10 cycles after release.
2. **24 h rollover:** `H24`=1, set 23:59:58 via SETUP, return to CLOCK → after 10 cycles 23:59:59, after 20 cycles 00:00:00 on a single edge, `o_sec_tick` one cycle wide each time.
3. **12 h range:** `H24`=0 → reset shows hour 12; 12:59:59 ticks to 01:00:00; in SETUP, inc on HOUR from 12 → 1.
4. **Debounce:** a 3-cycle low glitch → no event; a 10-cycle press with 1-cycle bounces in its first 2 cycles → exactly one event; a held button → one event.
5. **Setup edit:** SETUP, 61 inc events on SEC from 00:00:00 → `o_sec`=1, `o_min`=0; no ticks and `o_blink` toggling every 5 cycles while in SETUP; pos ×3 → `o_pos` back to 0.
6. **Simultaneous events:**
   - Mode+inc in the same cycle in CLOCK → `o_mode`=1, fields unchanged.
   - pos+inc in the same cycle at pos=MIN → minute increments, `o_pos`=2.

Source files
------------

// File: rtl/hms_pkg.sv
// Shared encodings and range helpers for the hour:minute:second clock core.
package hms_pkg;

    typedef enum logic {
        MODE_CLOCK = 1'b0,
        MODE_SETUP = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_t;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    function automatic logic [4:0] hour_min(input bit h24);
        return h24 ? 5'd0 : 5'd1;
    endfunction

    function automatic logic [4:0] hour_max(input bit h24);
        return h24 ? 5'd23 : 5'd12;
    endfunction

    // 12 h mode powers up showing 12 o'clock rather than the range minimum.
    function automatic logic [4:0] hour_rst(input bit h24);
        return h24 ? 5'd0 : 5'd12;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Button front end: 2-FF synchroniser, stability counter and press (1->0) event.
module sw_debounce #(
    parameter int DEB_CYC = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_level,
    output logic o_press
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            cnt     <= '0;
            o_level <= 1'b1;
            o_press <= 1'b0;
        end else begin
            sync_a  <= i_sw;
            sync_b  <= sync_a;
            o_press <= 1'b0;
            // Any sample matching the accepted level restarts the stability window.
            if (sync_b == o_level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYC - 1)) begin
                cnt     <= '0;
                o_level <= sync_b;
                o_press <= ~sync_b;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hms_clock_core.sv
// Hour:minute:second timekeeping core with debounced buttons, setup FSM and blink flag.
module hms_clock_core
    import hms_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int DEB_CYC  = 500_000,
    parameter int H24      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sw_mode,
    input  logic       i_sw_pos,
    input  logic       i_sw_inc,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_mode,
    output logic [1:0] o_pos,
    output logic       o_sec_tick,
    output logic       o_blink
);

    localparam int         PW     = $clog2(TICK_DIV);
    localparam int         HALF   = TICK_DIV / 2;
    localparam int         BW     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam bit         IS_24  = (H24 != 0);
    localparam logic [4:0] H_MIN  = hour_min(IS_24);
    localparam logic [4:0] H_MAX  = hour_max(IS_24);
    localparam logic [4:0] H_RST  = hour_rst(IS_24);

    logic [2:0] sw_level_unused;
    logic       mode_press;
    logic       pos_press;
    logic       inc_press;

    sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
        .clk(clk), .rst(rst), .i_sw(i_sw_mode), .o_level(sw_level_unused[0]), .o_press(mode_press)
    );
    sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb_pos (
        .clk(clk), .rst(rst), .i_sw(i_sw_pos), .o_level(sw_level_unused[1]), .o_press(pos_press)
    );
    sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
        .clk(clk), .rst(rst), .i_sw(i_sw_inc), .o_level(sw_level_unused[2]), .o_press(inc_press)
    );

    mode_t         mode;
    mode_t         mode_next;
    pos_t          pos;
    pos_t          pos_next;
    logic [PW-1:0] pre;
    logic [BW-1:0] blink_cnt;
    logic          tick;
    logic          setup_inc;

    function automatic logic [4:0] next_hour(input logic [4:0] h);
        return (h == H_MAX) ? H_MIN : h + 5'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= MODE_CLOCK;
            pos  <= POS_SEC;
        end else begin
            mode <= mode_next;
            pos  <= pos_next;
        end
    end

    always_comb begin
        mode_next = mode;
        pos_next  = pos;
        setup_inc = 1'b0;
        if (mode_press) begin
            mode_next = (mode == MODE_CLOCK) ? MODE_SETUP : MODE_CLOCK;
        end
        if (mode == MODE_SETUP) begin
            // A mode event in the same cycle swallows the increment.
            setup_inc = inc_press && !mode_press;
            if (pos_press) begin
                case (pos)
                    POS_SEC:  pos_next = POS_MIN;
                    POS_MIN:  pos_next = POS_HOUR;
                    default:  pos_next = POS_SEC;
                endcase
            end
        end
    end

    assign tick = (mode == MODE_CLOCK) && (pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre        <= '0;
            o_sec      <= '0;
            o_min      <= '0;
            o_hour     <= H_RST;
            o_sec_tick <= 1'b0;
        end else begin
            o_sec_tick <= tick;
            if (mode == MODE_SETUP || tick) begin
                pre <= '0;
            end else begin
                pre <= pre + PW'(1);
            end
            if (tick) begin
                if (o_sec == SEC_MAX) begin
                    o_sec <= '0;
                    if (o_min == MIN_MAX) begin
                        o_min  <= '0;
                        o_hour <= next_hour(o_hour);
                    end else begin
                        o_min <= o_min + 6'd1;
                    end
                end else begin
                    o_sec <= o_sec + 6'd1;
                end
            end else if (setup_inc) begin
                // Setup edits wrap inside the selected field without carry.
                case (pos)
                    POS_SEC:  o_sec  <= (o_sec == SEC_MAX) ? 6'd0 : o_sec + 6'd1;
                    POS_MIN:  o_min  <= (o_min == MIN_MAX) ? 6'd0 : o_min + 6'd1;
                    default:  o_hour <= next_hour(o_hour);
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            o_blink   <= 1'b1;
        end else if (mode_next == MODE_CLOCK || mode == MODE_CLOCK) begin
            blink_cnt <= '0;
            o_blink   <= 1'b1;
        end else if (blink_cnt == BW'(HALF - 1)) begin
            blink_cnt <= '0;
            o_blink   <= ~o_blink;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign o_mode = (mode == MODE_SETUP);
    assign o_pos  = pos;

endmodule

// File: tb/tb_hms_clock_core.sv
// Directed bench for hms_clock_core: one 24 h instance (a) and one 12 h instance (b).
module tb_hms_clock_core;

    localparam int TD = 10;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sw_a = 3'b111;
    logic [2:0] sw_b = 3'b111;

    logic [5:0] sec_a, min_a, sec_b, min_b;
    logic [4:0] hour_a, hour_b;
    logic       mode_a, mode_b, tick_a, tick_b, blink_a, blink_b;
    logic [1:0] pos_a, pos_b;

    int total = 0;
    int bad   = 0;
    int ticks_b = 0;
    int t0;
    bit found;

    always #5 clk = ~clk;

    hms_clock_core #(.TICK_DIV(TD), .DEB_CYC(DC), .H24(1)) dut_a (
        .clk(clk), .rst(rst),
        .i_sw_mode(sw_a[0]), .i_sw_pos(sw_a[1]), .i_sw_inc(sw_a[2]),
        .o_sec(sec_a), .o_min(min_a), .o_hour(hour_a), .o_mode(mode_a),
        .o_pos(pos_a), .o_sec_tick(tick_a), .o_blink(blink_a)
    );

    hms_clock_core #(.TICK_DIV(TD), .DEB_CYC(DC), .H24(0)) dut_b (
        .clk(clk), .rst(rst),
        .i_sw_mode(sw_b[0]), .i_sw_pos(sw_b[1]), .i_sw_inc(sw_b[2]),
        .o_sec(sec_b), .o_min(min_b), .o_hour(hour_b), .o_mode(mode_b),
        .o_pos(pos_b), .o_sec_tick(tick_b), .o_blink(blink_b)
    );

    always @(negedge clk) if (tick_b === 1'b1) ticks_b <= ticks_b + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // mask bits: 0 = mode, 1 = pos, 2 = inc; all masked buttons pressed together.
    task automatic tap(input bit dut, input logic [2:0] mask);
        if (dut) sw_b = sw_b & ~mask; else sw_a = sw_a & ~mask;
        repeat (8) @(negedge clk);
        sw_a = 3'b111;
        sw_b = 3'b111;
        repeat (8) @(negedge clk);
    endtask

    // Presses mode until the instance drops back to CLOCK; returns on the negedge after that edge.
    task automatic leave_setup(input bit dut);
        found = 1'b0;
        if (dut) sw_b[0] = 1'b0; else sw_a[0] = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clk);
            if ((dut ? mode_b : mode_a) == 1'b0) found = 1'b1;
        end
        sw_a[0] = 1'b1;
        sw_b[0] = 1'b1;
        check_val("leave_setup_seen", found, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_sec", sec_a, 0);
        check_val("rst_min", min_a, 0);
        check_val("rst_hour24", hour_a, 0);
        check_val("rst_hour12", hour_b, 12);
        check_val("rst_mode", mode_a, 0);
        check_val("rst_pos", pos_a, 0);
        check_val("rst_tick", tick_a, 0);
        check_val("rst_blink", blink_a, 1);
        rst = 1'b0;

        // Mid-run asynchronous reset, then first tick timing
        repeat (25) @(negedge clk);
        check_val("run_sec", sec_a, 2);
        #2 rst = 1'b1;
        #1;
        check_val("async_sec", sec_a, 0);
        check_val("async_hour12", hour_b, 12);
        @(negedge clk);
        rst = 1'b0;
        repeat (9) @(negedge clk);
        check_val("pre_tick", tick_a, 0);
        check_val("pre_tick_sec", sec_a, 0);
        @(negedge clk);
        check_val("first_tick", tick_a, 1);
        check_val("first_tick_sec", sec_a, 1);
        @(negedge clk);
        check_val("tick_width", tick_a, 0);

        // Held mode button through reset: SETUP entered at edge 7, blink from entry
        rst = 1'b1;
        sw_a = 3'b110;
        sw_b = 3'b110;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_val("held_mode_e6", mode_a, 0);
        @(negedge clk);
        check_val("held_mode_e7", mode_a, 1);
        check_val("held_mode_b", mode_b, 1);
        check_val("setup_sec", sec_a, 0);
        check_val("blink_entry", blink_a, 1);
        repeat (4) @(negedge clk);
        check_val("blink_e11", blink_a, 1);
        @(negedge clk);
        check_val("blink_e12", blink_a, 0);
        repeat (4) @(negedge clk);
        check_val("blink_e16", blink_a, 0);
        @(negedge clk);
        check_val("blink_e17", blink_a, 1);
        sw_a = 3'b111;
        sw_b = 3'b111;
        repeat (10) @(negedge clk);
        check_val("held_one_event", mode_a, 1);
        t0 = ticks_b;

        // 24 h: set 23:59:58 and roll over
        repeat (58) tap(0, 3'b100);
        tap(0, 3'b010);
        repeat (59) tap(0, 3'b100);
        tap(0, 3'b010);
        repeat (23) tap(0, 3'b100);
        check_val("set24_sec", sec_a, 58);
        check_val("set24_min", min_a, 59);
        check_val("set24_hour", hour_a, 23);
        check_val("set24_pos", pos_a, 2);
        leave_setup(0);
        repeat (9) @(negedge clk);
        check_val("r24_pre_tick", tick_a, 0);
        check_val("r24_pre_sec", sec_a, 58);
        @(negedge clk);
        check_val("r24_tick1", tick_a, 1);
        check_val("r24_sec59", sec_a, 59);
        @(negedge clk);
        check_val("r24_tick1_width", tick_a, 0);
        repeat (8) @(negedge clk);
        check_val("r24_hold_sec", sec_a, 59);
        @(negedge clk);
        check_val("r24_tick2", tick_a, 1);
        check_val("r24_sec0", sec_a, 0);
        check_val("r24_min0", min_a, 0);
        check_val("r24_hour0", hour_a, 0);
        @(negedge clk);
        check_val("r24_tick2_width", tick_a, 0);

        // 12 h instance: 61 second increments, then 12:59:59 rollover
        repeat (61) tap(1, 3'b100);
        check_val("edit_sec", sec_b, 1);
        check_val("edit_min", min_b, 0);
        check_val("edit_hour", hour_b, 12);
        check_val("setup_no_ticks", ticks_b - t0, 0);
        repeat (58) tap(1, 3'b100);
        tap(1, 3'b010);
        repeat (59) tap(1, 3'b100);
        tap(1, 3'b010);
        check_val("pos_hour", pos_b, 2);
        tap(1, 3'b100);
        check_val("h12_wrap", hour_b, 1);
        repeat (11) tap(1, 3'b100);
        check_val("set12_hour", hour_b, 12);
        check_val("set12_min", min_b, 59);
        check_val("set12_sec", sec_b, 59);
        tap(1, 3'b010);
        check_val("pos_x3", pos_b, 0);
        leave_setup(1);
        repeat (9) @(negedge clk);
        check_val("r12_pre_sec", sec_b, 59);
        @(negedge clk);
        check_val("r12_tick", tick_b, 1);
        check_val("r12_sec", sec_b, 0);
        check_val("r12_min", min_b, 0);
        check_val("r12_hour", hour_b, 1);

        // Mode + inc together in CLOCK: toggle applies, inc dropped
        rst = 1'b1;
        sw_a = 3'b010;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_val("mi_mode", mode_a, 1);
        check_val("mi_sec", sec_a, 0);
        check_val("mi_min", min_a, 0);
        check_val("mi_hour", hour_a, 0);
        sw_a = 3'b111;
        repeat (10) @(negedge clk);

        // pos + inc together at MIN: minute edited, then pos advances
        tap(0, 3'b010);
        check_val("pi_pos_min", pos_a, 1);
        tap(0, 3'b110);
        check_val("pi_min", min_a, 1);
        check_val("pi_pos", pos_a, 2);
        check_val("pi_sec", sec_a, 0);
        tap(0, 3'b010);
        check_val("deb_pos_sec", pos_a, 0);

        // Debounce: short glitch, bouncy press, held press
        sw_a[2] = 1'b0;
        repeat (3) @(negedge clk);
        sw_a[2] = 1'b1;
        repeat (12) @(negedge clk);
        check_val("glitch", sec_a, 0);
        for (int i = 0; i < 10; i++) begin
            sw_a[2] = (i == 1) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        sw_a[2] = 1'b1;
        repeat (12) @(negedge clk);
        check_val("bounce", sec_a, 1);
        sw_a[2] = 1'b0;
        repeat (20) @(negedge clk);
        check_val("held_mid", sec_a, 2);
        repeat (20) @(negedge clk);
        check_val("held_late", sec_a, 2);
        sw_a[2] = 1'b1;
        repeat (12) @(negedge clk);
        check_val("held_release", sec_a, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
